// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game controller: state encodings,
// default game parameters and the LED blink divisor.
package breakout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } game_state_e;

    localparam int unsigned LIVES_INIT_DEF  = 3;
    localparam int unsigned BRICK_COUNT_DEF = 40;
    localparam int unsigned BLINK_DIV_DEF   = 25_000_000;

    // Number of lit lives LEDs, capped at three.
    function automatic logic [2:0] lives_therm(input logic [2:0] l);
        if (l >= 3'd3)      return 3'b111;
        else if (l == 3'd2) return 3'b011;
        else if (l == 3'd1) return 3'b001;
        else                return 3'b000;
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter and a one-cycle
// press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          armed_q, armed_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sample;

    assign sample  = sync_q[1];
    assign press_o = press_q;

    // Until armed, the counter instead measures a debounced release, so a
    // button held through reset cannot produce a press.
    always_comb begin
        level_d = level_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!armed_q) begin
            if (sample) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                armed_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sample;
            press_d = sample;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game sequencer: button handling, serve/play/pause flow, lives and
// score bookkeeping, physics stepping and status LEDs.
module breakout_game_ctrl
    import breakout_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LIVES_INIT      = LIVES_INIT_DEF,
    parameter int unsigned BRICK_COUNT     = BRICK_COUNT_DEF,
    parameter int unsigned BLINK_DIV       = BLINK_DIV_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       frame_start,
    input  logic       ball_lost,
    input  logic       brick_hit,
    output logic       phys_step,
    output logic       ball_reset,
    output logic [2:0] game_state,
    output logic [2:0] lives,
    output logic [7:0] score,
    output logic [4:0] led
);

    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    game_state_e   state_q, state_d;
    logic [2:0]    lives_q, lives_d;
    logic [7:0]    score_q, score_d;
    logic [7:0]    bricks_q, bricks_d;
    logic          phys_step_q, phys_step_d;
    logic          ball_reset_q, ball_reset_d;
    logic [4:0]    led_q, led_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          start_ev, pause_press, pause_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_start),
        .press_o (start_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
        .clk     (clk),
        .rst_n   (reset),
        .btn_i   (btn_pause),
        .press_o (pause_press)
    );

    assign pause_ev = pause_press & ~start_ev;

    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
            blink_d     = blink_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        score_d      = score_q;
        bricks_d     = bricks_q;
        ball_reset_d = 1'b0;
        phys_step_d  = (state_q == ST_PLAY) && frame_start;

        case (state_q)
            ST_IDLE: begin
                if (start_ev) begin
                    lives_d      = 3'(LIVES_INIT);
                    score_d      = '0;
                    bricks_d     = 8'(BRICK_COUNT);
                    ball_reset_d = 1'b1;
                    state_d      = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (start_ev) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                // Brick is counted before a simultaneous ball loss; clearing
                // the last brick wins outright and the loss is discarded.
                if (brick_hit) begin
                    if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    bricks_d = bricks_q - 8'd1;
                end
                if (brick_hit && (bricks_q == 8'd1)) begin
                    state_d = ST_WIN;
                end else if (ball_lost) begin
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d      = ST_SERVE;
                        ball_reset_d = 1'b1;
                    end
                end else if (pause_ev) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_ev) state_d = ST_PLAY;
            end
            ST_OVER, ST_WIN: begin
                if (start_ev) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        led_d      = '0;
        led_d[2:0] = lives_therm(lives_d);
        led_d[3]   = (state_d == ST_PAUSE);
        led_d[4]   = (state_d == ST_OVER) ? blink_d : (state_d == ST_WIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= '0;
            score_q      <= '0;
            bricks_q     <= '0;
            phys_step_q  <= 1'b0;
            ball_reset_q <= 1'b0;
            led_q        <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            bricks_q     <= bricks_d;
            phys_step_q  <= phys_step_d;
            ball_reset_q <= ball_reset_d;
            led_q        <= led_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
        end
    end

    assign phys_step  = phys_step_q;
    assign ball_reset = ball_reset_q;
    assign game_state = state_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign led        = led_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Self-checking bench for breakout_game_ctrl: directed scenarios, a vector
// table and a randomized play phase against a rule-level model.
module tb_breakout_game_ctrl;

    localparam int D     = 4;
    localparam int BLINK = 16;
    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_OVER = 4, S_WIN = 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_start = 1'b0, btn_pause = 1'b0;
    logic frame_start = 1'b0, ball_lost = 1'b0, brick_hit = 1'b0;

    logic       phys_step, ball_reset;
    logic [2:0] game_state, lives;
    logic [7:0] score;
    logic [4:0] led;

    logic       s_phys_step, s_ball_reset;
    logic [2:0] s_game_state, s_lives;
    logic [7:0] s_score;
    logic [4:0] s_led;

    int n_cmp = 0, n_fail = 0;
    int br_cnt = 0, phys_cnt = 0, cyc = 0;

    breakout_game_ctrl #(
        .DEBOUNCE_CYCLES(D), .LIVES_INIT(3), .BRICK_COUNT(40), .BLINK_DIV(BLINK)
    ) dut (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
        .frame_start(frame_start), .ball_lost(ball_lost), .brick_hit(brick_hit),
        .phys_step(phys_step), .ball_reset(ball_reset), .game_state(game_state),
        .lives(lives), .score(score), .led(led)
    );

    breakout_game_ctrl #(
        .DEBOUNCE_CYCLES(D), .LIVES_INIT(3), .BRICK_COUNT(255), .BLINK_DIV(BLINK)
    ) u_sat (
        .clk(clk), .reset(reset), .btn_start(btn_start), .btn_pause(btn_pause),
        .frame_start(frame_start), .ball_lost(ball_lost), .brick_hit(brick_hit),
        .phys_step(s_phys_step), .ball_reset(s_ball_reset), .game_state(s_game_state),
        .lives(s_lives), .score(s_score), .led(s_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ball_reset) br_cnt <= br_cnt + 1;
        if (phys_step)  phys_cnt <= phys_cnt + 1;
    end

    typedef struct {
        logic frame, brick, lost;
        int   st, lv, sc;
        logic ph, br;
    } vec_t;
    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        repeat (D + 6) tick();
        btn_start = 1'b0;
        repeat (D + 6) tick();
    endtask

    task automatic press_pause();
        btn_pause = 1'b1;
        repeat (D + 6) tick();
        btn_pause = 1'b0;
        repeat (D + 6) tick();
    endtask

    task automatic frame_pulse(input string name, input int exp_ph);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk(name, int'(phys_step), exp_ph);
        tick();
        chk({name, "_after"}, int'(phys_step), 0);
        tick();
    endtask

    function automatic int therm(input int l);
        int n;
        n = (l > 3) ? 3 : l;
        return (1 << n) - 1;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (D + 6) tick();
    endtask

    initial begin
        int base, t0, m_state, m_lives, m_score, m_bricks, exp_ph, exp_br;
        logic prev, got, fr, br, lo;

        tbl[0] = '{frame:1, brick:0, lost:0, st:S_PLAY,  lv:3, sc:0, ph:1, br:0};
        tbl[1] = '{frame:0, brick:1, lost:0, st:S_PLAY,  lv:3, sc:1, ph:0, br:0};
        tbl[2] = '{frame:1, brick:1, lost:0, st:S_PLAY,  lv:3, sc:2, ph:1, br:0};
        tbl[3] = '{frame:0, brick:0, lost:0, st:S_PLAY,  lv:3, sc:2, ph:0, br:0};
        tbl[4] = '{frame:0, brick:1, lost:1, st:S_SERVE, lv:2, sc:3, ph:0, br:1};

        // Reset state
        repeat (3) tick();
        chk("rst_state", int'(game_state), S_IDLE);
        chk("rst_lives", int'(lives), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_phys", int'(phys_step), 0);
        chk("rst_ball_reset", int'(ball_reset), 0);
        reset = 1'b1;
        repeat (D + 6) tick();

        // Debounce: short glitch rejected, long press accepted once
        btn_start = 1'b1;
        repeat (3) tick();
        btn_start = 1'b0;
        repeat (12) tick();
        chk("glitch_state", int'(game_state), S_IDLE);
        chk("glitch_br", br_cnt, 0);
        press_start();
        chk("serve_state", int'(game_state), S_SERVE);
        chk("serve_lives", int'(lives), 3);
        chk("serve_score", int'(score), 0);
        chk("serve_br", br_cnt, 1);
        chk("serve_led", int'(led), 7);

        // Frame stepping in PLAY and PAUSE
        press_start();
        chk("play_state", int'(game_state), S_PLAY);
        base = phys_cnt;
        for (int i = 0; i < 3; i++) frame_pulse("play_phys", 1);
        chk("play_phys_cnt", phys_cnt - base, 3);
        press_pause();
        chk("pause_state", int'(game_state), S_PAUSE);
        chk("pause_led3", int'(led[3]), 1);
        base = phys_cnt;
        for (int i = 0; i < 3; i++) frame_pulse("pause_phys", 0);
        chk("pause_phys_cnt", phys_cnt - base, 0);
        brick_hit = 1'b1; ball_lost = 1'b1;
        tick();
        brick_hit = 1'b0; ball_lost = 1'b0;
        tick();
        chk("pause_ignore_score", int'(score), 0);
        chk("pause_ignore_lives", int'(lives), 3);
        press_start();
        chk("pause_start_ignored", int'(game_state), S_PAUSE);
        press_pause();
        chk("unpause_state", int'(game_state), S_PLAY);
        chk("unpause_led3", int'(led[3]), 0);

        // Vector table from a fresh PLAY
        base = br_cnt;
        foreach (tbl[i]) begin
            frame_start = tbl[i].frame;
            brick_hit   = tbl[i].brick;
            ball_lost   = tbl[i].lost;
            tick();
            frame_start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
            chk($sformatf("tbl%0d_state", i), int'(game_state), tbl[i].st);
            chk($sformatf("tbl%0d_lives", i), int'(lives), tbl[i].lv);
            chk($sformatf("tbl%0d_score", i), int'(score), tbl[i].sc);
            chk($sformatf("tbl%0d_phys", i), int'(phys_step), int'(tbl[i].ph));
            chk($sformatf("tbl%0d_ball_reset", i), int'(ball_reset), int'(tbl[i].br));
        end
        tick();
        chk("tbl_br_cnt", br_cnt - base, 1);

        // Remaining life losses down to OVER
        press_start();
        chk("reserve1_state", int'(game_state), S_PLAY);
        ball_lost = 1'b1; tick(); ball_lost = 1'b0;
        chk("loss2_state", int'(game_state), S_SERVE);
        chk("loss2_lives", int'(lives), 1);
        chk("loss2_led", int'(led[2:0]), 1);
        press_start();
        base = br_cnt;
        ball_lost = 1'b1; tick(); ball_lost = 1'b0;
        chk("loss3_state", int'(game_state), S_OVER);
        chk("loss3_lives", int'(lives), 0);
        chk("loss3_led", int'(led[3:0]), 0);
        tick();
        chk("loss3_no_br", br_cnt - base, 0);
        brick_hit = 1'b1; tick(); brick_hit = 1'b0; tick();
        chk("over_hold_score", int'(score), 3);

        // Blink period in OVER
        prev = led[4]; got = 1'b0;
        for (int i = 0; i < 4 * BLINK && !got; i++) begin
            tick();
            if (led[4] != prev) got = 1'b1;
        end
        chk("blink_edge", int'(got), 1);
        t0 = cyc; prev = led[4]; got = 1'b0;
        for (int i = 0; i < 4 * BLINK && !got; i++) begin
            tick();
            if (led[4] != prev) got = 1'b1;
        end
        chk("blink_edge2", int'(got), 1);
        chk("blink_period", cyc - t0, BLINK);

        // Win with simultaneous brick_hit and ball_lost on the last brick
        press_start();
        chk("over_to_idle", int'(game_state), S_IDLE);
        press_start();
        chk("new_game_score", int'(score), 0);
        press_start();
        for (int i = 0; i < 39; i++) begin
            brick_hit = 1'b1; tick(); brick_hit = 1'b0; tick();
        end
        chk("pre_win_score", int'(score), 39);
        chk("pre_win_state", int'(game_state), S_PLAY);
        brick_hit = 1'b1; ball_lost = 1'b1; tick();
        brick_hit = 1'b0; ball_lost = 1'b0;
        chk("win_state", int'(game_state), S_WIN);
        chk("win_score", int'(score), 40);
        chk("win_lives", int'(lives), 3);
        chk("win_led", int'(led), 5'b10111);

        // Reset mid-PLAY with start held through release
        press_start(); press_start(); press_start();
        chk("pre_rst_state", int'(game_state), S_PLAY);
        base = br_cnt;
        btn_start = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_async_state", int'(game_state), S_IDLE);
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        chk("held_state", int'(game_state), S_IDLE);
        chk("held_lives", int'(lives), 0);
        chk("held_score", int'(score), 0);
        chk("held_led", int'(led), 0);
        chk("held_phys", int'(phys_step), 0);
        chk("held_br", br_cnt - base, 0);
        btn_start = 1'b0;
        repeat (D + 6) tick();
        chk("release_state", int'(game_state), S_IDLE);
        press_start();
        chk("repress_state", int'(game_state), S_SERVE);

        // Randomized play against the rule model
        press_start();
        m_state = S_PLAY; m_lives = 3; m_score = 0; m_bricks = 40;
        for (int it = 0; it < 600; it++) begin
            if (m_state == S_SERVE) begin
                press_start();
                m_state = S_PLAY;
                chk("rnd_reserve", int'(game_state), m_state);
            end else if (m_state == S_OVER || m_state == S_WIN) begin
                press_start();
                chk("rnd_idle", int'(game_state), S_IDLE);
                press_start();
                chk("rnd_serve_lives", int'(lives), 3);
                press_start();
                m_state = S_PLAY; m_lives = 3; m_score = 0; m_bricks = 40;
                chk("rnd_play", int'(game_state), m_state);
            end else begin
                fr = ($urandom_range(2) == 0);
                br = ($urandom_range(3) == 0);
                lo = ($urandom_range(19) == 0);
                frame_start = fr; brick_hit = br; ball_lost = lo;
                tick();
                frame_start = 1'b0; brick_hit = 1'b0; ball_lost = 1'b0;
                exp_ph = int'(fr);
                exp_br = 0;
                if (br) begin
                    m_score = (m_score < 255) ? m_score + 1 : 255;
                    m_bricks = m_bricks - 1;
                end
                if (br && m_bricks == 0) begin
                    m_state = S_WIN;
                end else if (lo) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = S_OVER;
                    else begin m_state = S_SERVE; exp_br = 1; end
                end
                chk("rnd_state", int'(game_state), m_state);
                chk("rnd_lives", int'(lives), m_lives);
                chk("rnd_score", int'(score), m_score);
                chk("rnd_phys", int'(phys_step), exp_ph);
                chk("rnd_ball_reset", int'(ball_reset), exp_br);
                chk("rnd_led", int'(led[3:0]), therm(m_lives));
                if (m_state == S_WIN) chk("rnd_led4", int'(led[4]), 1);
                else if (m_state != S_OVER) chk("rnd_led4", int'(led[4]), 0);
            end
        end

        // Score saturation with 255 bricks
        do_reset();
        press_start();
        press_start();
        chk("sat_play", int'(s_game_state), S_PLAY);
        for (int i = 0; i < 300; i++) begin
            brick_hit = 1'b1; tick(); brick_hit = 1'b0; tick();
            if (i == 253) chk("sat_254", int'(s_score), 254);
            if (i == 254) chk("sat_win_state", int'(s_game_state), S_WIN);
        end
        chk("sat_score", int'(s_score), 255);
        chk("sat_state", int'(s_game_state), S_WIN);
        chk("sat_lives", int'(s_lives), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- DEBOUNCE_CYCLES, 500000, stable-input clock count before a button edge is accepted (10 ms at 50 MHz).
- LIVES_INIT, 3, lives at game start (1..7).
- BRICK_COUNT, 40, bricks per level (1..255).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, 50 MHz system clock.
- reset, in, 1, asynchronous active-low reset.
- btn_start, in, 1, raw start/serve button, active-high, asynchronous to clk.
- btn_pause, in, 1, raw pause button, active-high, asynchronous to clk.
- frame_start, in, 1, one-cycle pulse at start of vertical blanking.
- ball_lost, in, 1, one-cycle pulse from ball physics: ball passed below paddle.
- brick_hit, in, 1, one-cycle pulse from ball physics: one brick destroyed.
- phys_step, out, 1, one-cycle pulse enabling one ball/paddle update.
- ball_reset, out, 1, one-cycle pulse: re-centre ball on paddle, restore brick map.
- game_state, out, 3, current FSM state encoding.
- lives, out, 3, remaining lives.
- score, out, 8, bricks destroyed this game.
- led, out, 5, status LEDs.

Function
REQ-003 Each button SHALL pass a 2-flop synchronizer, then a debounce counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-004 A press event SHALL be a single-cycle pulse on the debounced 0->1 edge; holding a button SHALL generate no further events.
REQ-005 FSM states SHALL be: IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4, WIN=5.
REQ-006 In IDLE, a start press SHALL load lives=LIVES_INIT, score=0, bricks_left=BRICK_COUNT, pulse ball_reset, and move to SERVE.
REQ-007 In SERVE, a start press SHALL move to PLAY; phys_step stays low.
REQ-008 In PLAY, phys_step SHALL pulse exactly one cycle after each frame_start; no phys_step is issued in any other state.
REQ-009 In PLAY, a pause press SHALL move to PAUSE; in PAUSE, a pause press SHALL return to PLAY; a start press in PAUSE is ignored.
REQ-010 In PLAY, brick_hit SHALL increment score (saturating at 255) and decrement bricks_left; when bricks_left reaches 0, the state SHALL go to WIN.
REQ-011 In PLAY, ball_lost SHALL decrement lives. If lives becomes 0, the state SHALL go to OVER. Otherwise it SHALL pulse ball_reset and go to SERVE.
REQ-012 If brick_hit and ball_lost are asserted in the same cycle, the brick SHALL be counted first; WIN SHALL take priority over any life loss, and lives remain unchanged on WIN.
REQ-013 ball_lost and brick_hit SHALL be ignored outside PLAY, including PAUSE.
REQ-014 In OVER or WIN, a start press SHALL return to IDLE; score and lives hold their values until then.
REQ-015 A pause press and a start press in the same cycle SHALL be treated as start only.
REQ-016 led[2:0] SHALL be a thermometer of lives (min(lives,3) LEDs lit); led[3] SHALL be high in PAUSE; led[4] SHALL blink at 1 Hz in OVER and be steady high in WIN, otherwise low.
REQ-017 All outputs SHALL be registered; event-to-output latency is 1 clk.

Reset
REQ-018 On reset low, the block SHALL be in state IDLE with lives=0, score=0, bricks_left=0, phys_step=0, ball_reset=0, led=0, debounce counters and synchronizers cleared to the "not pressed" state.
REQ-019 Reset asserted mid-game SHALL abort immediately; after release the block SHALL wait in IDLE with no spurious press event, even if a button is held through the release.

Structure
REQ-020 The state encodings, LIVES_INIT and BRICK_COUNT defaults SHALL live in a shared package breakout_pkg, together with the 1 Hz blink divisor (25_000_000).
REQ-021 The debouncer and edge detector SHALL be one sub-module, btn_debounce, instantiated once per button.

Verification
REQ-022 Verification SHALL cover these directed scenarios (DEBOUNCE_CYCLES=4 for simulation):
- Debounce: btn_start glitch of 3 clk -> no event; held 10 clk -> exactly one event; IDLE->SERVE, lives=3, one ball_reset pulse.
- Frame stepping: in PLAY, 3 frame_start pulses -> exactly 3 phys_step pulses, each 1 clk after its frame_start; in PAUSE, 3 frame_start pulses -> 0 phys_step pulses.
- Life loss: 3 ball_lost pulses with re-serves -> lives 3->2->1->0, SERVE twice, then OVER; led[4] toggles every 25e6 clk.
- Win with simultaneous event: bricks_left=1, brick_hit and ball_lost in the same cycle -> WIN, score=40, lives unchanged.
- Saturation: BRICK_COUNT=255 override, 300 brick_hit pulses spread across replayed levels -> score holds at 255.
- Reset mid-PLAY with btn_start held through release -> IDLE, all outputs 0, no transition to SERVE until the button is released and pressed again.
